// File: rtl/hazard_if.sv
// Fetch-side hazard/redirect bundle: pipeline status into the controller,
// hold and redirect controls back out to the fetch unit.
interface hazard_if;
    logic [31:0] pc;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic        ex_mem_read;
    logic [4:0]  ex_rd;
    logic        md_start;
    logic        ex_redirect;
    logic [31:0] ex_target;
    logic [2:0]  ex_op;
    logic        stop;
    logic [31:0] ori_pc;
    logic        jmp;
    logic [31:0] dest;
    logic [2:0]  op;
    logic        flush_id;
    logic        bubble_ex;
    logic        md_busy;

    modport master (
        input  pc, id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_rd,
               md_start, ex_redirect, ex_target, ex_op,
        output stop, ori_pc, jmp, dest, op, flush_id, bubble_ex, md_busy
    );

    modport slave (
        output pc, id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_rd,
               md_start, ex_redirect, ex_target, ex_op,
        input  stop, ori_pc, jmp, dest, op, flush_id, bubble_ex, md_busy
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and redirect controller. Detects load-use hazards,
// multiply/divide occupancy and execute redirects, and sequences the
// matching fetch stall or flush with a small FSM plus down-counter.
module hazard_ctrl #(
    parameter int LOAD_STALL = 1,
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 6
) (
    input logic       clk,
    input logic       rst_n,
    hazard_if.master  bus
);

    typedef enum logic [1:0] {RUN, LD_STALL, MD_BUSY} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             load_use;
    logic             stall_free;

    // Decode source matches a pending load destination (r0 never hazards).
    assign load_use = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                      ((bus.id_uses_rs && (bus.id_rs == bus.ex_rd)) ||
                       (bus.id_uses_rt && (bus.id_rt == bus.ex_rd)));

    // The final stall cycle behaves like RUN so a new hazard chains without a gap.
    assign stall_free = (state == RUN) || (cnt == '0);

    // Single FSM: redirect beats md_start beats load_use; all outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= RUN;
            cnt       <= '0;
            bus.stop      <= 1'b0;
            bus.ori_pc    <= 32'd0;
            bus.jmp       <= 1'b0;
            bus.dest      <= 32'd0;
            bus.op        <= 3'd0;
            bus.flush_id  <= 1'b0;
            bus.bubble_ex <= 1'b0;
            bus.md_busy   <= 1'b0;
        end else begin
            bus.jmp      <= 1'b0;
            bus.flush_id <= 1'b0;
            if (bus.ex_redirect) begin
                bus.jmp       <= 1'b1;
                bus.dest      <= bus.ex_target;
                bus.op        <= bus.ex_op;
                bus.flush_id  <= 1'b1;
                bus.stop      <= 1'b0;
                bus.bubble_ex <= 1'b0;
                bus.md_busy   <= 1'b0;
                cnt           <= '0;
                state         <= RUN;
            end else if (stall_free) begin
                if (bus.md_start) begin
                    bus.ori_pc    <= bus.pc;
                    bus.stop      <= 1'b1;
                    bus.bubble_ex <= 1'b1;
                    bus.md_busy   <= 1'b1;
                    cnt           <= CNT_W'(MD_LATENCY - 1);
                    state         <= MD_BUSY;
                end else if (load_use) begin
                    bus.ori_pc    <= bus.pc;
                    bus.stop      <= 1'b1;
                    bus.bubble_ex <= 1'b1;
                    bus.md_busy   <= 1'b0;
                    cnt           <= CNT_W'(LOAD_STALL - 1);
                    state         <= LD_STALL;
                end else begin
                    bus.stop      <= 1'b0;
                    bus.bubble_ex <= 1'b0;
                    bus.md_busy   <= 1'b0;
                    cnt           <= '0;
                    state         <= RUN;
                end
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl (LOAD_STALL=1, MD_LATENCY=32).
module tb_hazard_ctrl;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    hazard_if bus ();

    hazard_ctrl #(.LOAD_STALL(1), .MD_LATENCY(32), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.id_rs       = 5'd0;
        bus.id_rt       = 5'd0;
        bus.id_uses_rs  = 1'b0;
        bus.id_uses_rt  = 1'b0;
        bus.ex_mem_read = 1'b0;
        bus.ex_rd       = 5'd0;
        bus.md_start    = 1'b0;
        bus.ex_redirect = 1'b0;
        bus.ex_target   = 32'd0;
        bus.ex_op       = 3'd0;
    endtask

    task automatic set_load(input logic [4:0] rd, input logic [31:0] pcv);
        bus.ex_mem_read = 1'b1;
        bus.ex_rd       = rd;
        bus.id_rs       = 5'd8;
        bus.id_uses_rs  = 1'b1;
        bus.pc          = pcv;
    endtask

    task automatic test_reset();
        logic [103:0] obs;
        rst_n = 1'b0;
        clear_inputs();
        bus.pc = 32'd0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            obs = {bus.stop, bus.ori_pc, bus.jmp, bus.dest, bus.op, bus.flush_id,
                   bus.bubble_ex, bus.md_busy, 1'b0};
            n_cmp++;
            if (obs !== 104'd0) begin
                n_fail++;
                $display("FAIL reset_idle cycle %0d: outputs=%h required 0", i, obs);
            end
        end
    endtask

    task automatic test_load_use();
        // rs match -> one stall cycle at pc 0x40
        set_load(5'd8, 32'h40);
        tick();
        clear_inputs();
        bus.pc = 32'h44;
        n_cmp++;
        if ({bus.stop, bus.bubble_ex, bus.md_busy, bus.ori_pc} !== {3'b110, 32'h40}) begin
            n_fail++;
            $display("FAIL load_stall: stop/bub/md/ori=%b%b%b/%h required 110/00000040",
                     bus.stop, bus.bubble_ex, bus.md_busy, bus.ori_pc);
        end
        tick();
        n_cmp++;
        if ({bus.stop, bus.bubble_ex} !== 2'b00) begin
            n_fail++;
            $display("FAIL load_stall_end: stop/bub=%b%b required 00", bus.stop, bus.bubble_ex);
        end
        // ex_rd = 0 never hazards
        set_load(5'd0, 32'h48);
        bus.id_rs = 5'd0;
        tick();
        clear_inputs();
        n_cmp++;
        if (bus.stop !== 1'b0) begin
            n_fail++;
            $display("FAIL load_r0: stop=%b required 0", bus.stop);
        end
        // rt match
        bus.ex_mem_read = 1'b1;
        bus.ex_rd       = 5'd5;
        bus.id_rt       = 5'd5;
        bus.id_uses_rt  = 1'b1;
        bus.pc          = 32'h50;
        tick();
        clear_inputs();
        n_cmp++;
        if ({bus.stop, bus.ori_pc} !== {1'b1, 32'h50}) begin
            n_fail++;
            $display("FAIL load_rt: stop/ori=%b/%h required 1/00000050", bus.stop, bus.ori_pc);
        end
        tick();
        // matching register but not used -> no stall
        bus.ex_mem_read = 1'b1;
        bus.ex_rd       = 5'd7;
        bus.id_rs       = 5'd7;
        bus.id_rt       = 5'd7;
        tick();
        clear_inputs();
        n_cmp++;
        if (bus.stop !== 1'b0) begin
            n_fail++;
            $display("FAIL load_unused: stop=%b required 0", bus.stop);
        end
    endtask

    task automatic test_md();
        bus.md_start = 1'b1;
        bus.pc       = 32'h100;
        tick();
        clear_inputs();
        bus.pc = 32'h104;
        for (int k = 1; k <= 32; k++) begin
            n_cmp++;
            if ({bus.stop, bus.md_busy, bus.bubble_ex, bus.ori_pc} !== {3'b111, 32'h100}) begin
                n_fail++;
                $display("FAIL md_busy cycle %0d: stop/md/bub/ori=%b%b%b/%h required 111/00000100",
                         k, bus.stop, bus.md_busy, bus.bubble_ex, bus.ori_pc);
            end
            bus.md_start = (k == 10);
            if (k == 20) set_load(5'd8, 32'h300);
            else begin
                bus.ex_mem_read = 1'b0;
                bus.pc = 32'h200 + 32'(k);
            end
            tick();
        end
        clear_inputs();
        n_cmp++;
        if ({bus.stop, bus.md_busy, bus.bubble_ex} !== 3'b000) begin
            n_fail++;
            $display("FAIL md_end: stop/md/bub=%b%b%b required 000",
                     bus.stop, bus.md_busy, bus.bubble_ex);
        end
    endtask

    task automatic test_redirect();
        bus.md_start = 1'b1;
        bus.pc       = 32'h100;
        tick();
        clear_inputs();
        for (int k = 1; k <= 4; k++) tick();
        bus.ex_redirect = 1'b1;
        bus.ex_target   = 32'h200;
        bus.ex_op       = 3'd3;
        tick();
        clear_inputs();
        n_cmp++;
        if ({bus.jmp, bus.flush_id, bus.stop, bus.md_busy, bus.bubble_ex, bus.dest, bus.op} !==
            {5'b11000, 32'h200, 3'd3}) begin
            n_fail++;
            $display("FAIL redirect: jmp/fl/stop/md/bub=%b%b%b%b%b dest=%h op=%0d required 11000 00000200 3",
                     bus.jmp, bus.flush_id, bus.stop, bus.md_busy, bus.bubble_ex, bus.dest, bus.op);
        end
        tick();
        n_cmp++;
        if ({bus.jmp, bus.flush_id, bus.stop, bus.dest, bus.op} !== {3'b000, 32'h200, 3'd3}) begin
            n_fail++;
            $display("FAIL redirect_after: jmp/fl/stop=%b%b%b dest=%h op=%0d required 000 00000200 3",
                     bus.jmp, bus.flush_id, bus.stop, bus.dest, bus.op);
        end
    endtask

    task automatic test_priority();
        set_load(5'd8, 32'h50);
        bus.ex_redirect = 1'b1;
        bus.ex_target   = 32'h80;
        bus.ex_op       = 3'd5;
        tick();
        clear_inputs();
        n_cmp++;
        if ({bus.jmp, bus.stop, bus.bubble_ex, bus.dest, bus.op} !== {3'b100, 32'h80, 3'd5}) begin
            n_fail++;
            $display("FAIL redirect_vs_load: jmp/stop/bub=%b%b%b dest=%h op=%0d required 100 00000080 5",
                     bus.jmp, bus.stop, bus.bubble_ex, bus.dest, bus.op);
        end
        tick();
        n_cmp++;
        if (bus.stop !== 1'b0) begin
            n_fail++;
            $display("FAIL redirect_vs_load_after: stop=%b required 0", bus.stop);
        end
    endtask

    task automatic test_back_to_back();
        // load stall, new load in its final cycle
        set_load(5'd8, 32'h60);
        tick();
        bus.pc = 32'h64;
        n_cmp++;
        if ({bus.stop, bus.ori_pc} !== {1'b1, 32'h60}) begin
            n_fail++;
            $display("FAIL b2b_first: stop/ori=%b/%h required 1/00000060", bus.stop, bus.ori_pc);
        end
        tick();
        clear_inputs();
        n_cmp++;
        if ({bus.stop, bus.bubble_ex, bus.ori_pc} !== {2'b11, 32'h64}) begin
            n_fail++;
            $display("FAIL b2b_second: stop/bub/ori=%b%b/%h required 11/00000064",
                     bus.stop, bus.bubble_ex, bus.ori_pc);
        end
        tick();
        n_cmp++;
        if (bus.stop !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end: stop=%b required 0", bus.stop);
        end
        // md stall, load in its final cycle: stop continuous, md_busy drops
        bus.md_start = 1'b1;
        bus.pc       = 32'h100;
        tick();
        clear_inputs();
        for (int k = 1; k < 32; k++) tick();
        set_load(5'd8, 32'h120);
        tick();
        clear_inputs();
        n_cmp++;
        if ({bus.stop, bus.md_busy, bus.ori_pc} !== {2'b10, 32'h120}) begin
            n_fail++;
            $display("FAIL b2b_md_load: stop/md/ori=%b%b/%h required 10/00000120",
                     bus.stop, bus.md_busy, bus.ori_pc);
        end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        logic [103:0] obs;
        set_load(5'd8, 32'h70);
        tick();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        obs = {bus.stop, bus.ori_pc, bus.jmp, bus.dest, bus.op, bus.flush_id,
               bus.bubble_ex, bus.md_busy, 1'b0};
        n_cmp++;
        if (obs !== 104'd0) begin
            n_fail++;
            $display("FAIL reset_mid_ld: outputs=%h required 0", obs);
        end
        set_load(5'd8, 32'h74);
        tick();
        clear_inputs();
        n_cmp++;
        if ({bus.stop, bus.ori_pc} !== {1'b1, 32'h74}) begin
            n_fail++;
            $display("FAIL reset_fresh_load: stop/ori=%b/%h required 1/00000074", bus.stop, bus.ori_pc);
        end
        tick();
        // reset during md stall drops the pending stall
        bus.md_start = 1'b1;
        bus.pc       = 32'h180;
        tick();
        clear_inputs();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if ({bus.stop, bus.md_busy, bus.bubble_ex} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_mid_md: stop/md/bub=%b%b%b required 000",
                     bus.stop, bus.md_busy, bus.bubble_ex);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        bus.pc = 32'd0;
        clear_inputs();
        test_reset();
        test_load_use();
        test_md();
        test_redirect();
        test_priority();
        test_back_to_back();
        test_reset_mid_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
